// File: rtl/param_icache_if.sv
// Instruction-side bus bundle for param_icache: datapath request/response and memory fill port.
// The cache uses the slave modport; the datapath/memory environment uses master.
interface param_icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/param_icache.sv
// Direct-mapped instruction cache with block fill FSM and flush.
// Define PARAM_ICACHE_PERF_EN to add saturating hit_count/miss_count outputs.
module param_icache #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned WORDS = 2
) (
  input logic           CLK,
  input logic           nRST,
  param_icache_if.slave bus
`ifdef PARAM_ICACHE_PERF_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int unsigned OffBits = $clog2(WORDS);
  localparam int unsigned OffW    = (WORDS > 1) ? OffBits : 1;
  localparam int unsigned IdxW    = $clog2(SETS);
  localparam int unsigned TagLsb  = 2 + OffBits + IdxW;
  localparam int unsigned TagW    = 32 - TagLsb;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e          state_q, state_d;
  logic [OffW-1:0] cnt_q, cnt_d;
  logic [TagW-1:0] tag_q, tag_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [SETS-1:0] valid_q;
  logic [TagW-1:0] tag_arr_q [SETS];
  logic [31:0]     data_q    [SETS][WORDS];

  logic [31:0]     word_addr;
  logic [TagW-1:0] req_tag;
  logic [IdxW-1:0] req_idx;
  logic [OffW-1:0] req_off;
  logic            hit_raw;
  logic            fill_we;
  logic            line_done;
  logic            clear_valid;
  logic [31:0]     fill_addr;

  assign word_addr = bus.imemaddr >> 2;
  assign req_off   = OffW'(word_addr & 32'(WORDS - 1));
  assign req_idx   = IdxW'(word_addr >> OffBits);
  assign req_tag   = TagW'(bus.imemaddr >> TagLsb);

  assign hit_raw = (state_q == StIdle) && valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);

  // Outputs are gated by nRST so they read zero while reset is held, before the first edge.
  assign bus.ihit     = nRST && bus.imemREN && hit_raw && !bus.flush;
  assign bus.imemload = bus.ihit ? data_q[req_idx][req_off] : '0;
  assign bus.iREN     = nRST && (state_q == StFill);

  assign fill_addr = (32'(tag_q) << TagLsb) | (32'(idx_q) << (2 + OffBits)) | (32'(cnt_q) << 2);
  assign bus.iaddr = bus.iREN ? fill_addr : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    idx_d       = idx_q;
    fill_we     = 1'b0;
    line_done   = 1'b0;
    clear_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.flush) begin
          clear_valid = 1'b1;
        end else if (bus.imemREN && !hit_raw) begin
          state_d = StFill;
          tag_d   = req_tag;
          idx_d   = req_idx;
          cnt_d   = '0;
        end
      end
      StFill: begin
        // Flush beats a simultaneous last beat: the line is never marked valid.
        if (bus.flush) begin
          state_d     = StIdle;
          cnt_d       = '0;
          clear_valid = 1'b1;
        end else if (!bus.iwait) begin
          fill_we = 1'b1;
          if (cnt_q == OffW'(WORDS - 1)) begin
            line_done = 1'b1;
            state_d   = StIdle;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (clear_valid) begin
      valid_q <= '0;
    end else if (line_done) begin
      valid_q[idx_q] <= 1'b1;
    end
  end

  // Tag and data storage are not reset; valid_q alone qualifies them.
  always_ff @(posedge CLK) begin
    if (line_done) begin
      tag_arr_q[idx_q] <= tag_q;
    end
    if (fill_we) begin
      data_q[idx_q][cnt_q] <= bus.iload;
    end
  end

`ifdef PARAM_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        miss_start;

  assign miss_start = (state_q == StIdle) && (state_d == StFill);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (bus.ihit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_start && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_param_icache.sv
// Scoreboard bench for param_icache (SETS=16, WORDS=2): stimulus queues expected fill
// addresses and hit data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_param_icache;
  localparam int unsigned WORDS = 2;

  logic CLK;
  logic nRST;
  param_icache_if bus ();

`ifdef PARAM_ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  param_icache #(
    .SETS (16),
    .WORDS(WORDS)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
`ifdef PARAM_ICACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] hit_q  [$];
  logic [31:0] fill_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
  endfunction

  assign bus.iload = mem_word(bus.iaddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: data on every hit, address on every fill cycle, zeros otherwise.
  always @(negedge CLK) begin
    if (bus.ihit) begin
      if (hit_q.size() == 0) chk("unexpected ihit", 32'd1, 32'd0);
      else chk("imemload", bus.imemload, hit_q.pop_front());
    end else begin
      chk("imemload idle", bus.imemload, 32'd0);
    end
    if (bus.iREN) begin
      if (fill_q.size() == 0) chk("unexpected iREN", 32'd1, 32'd0);
      else if (bus.iwait) chk("iaddr held", bus.iaddr, fill_q[0]);
      else chk("iaddr beat", bus.iaddr, fill_q.pop_front());
    end else begin
      chk("iaddr idle", bus.iaddr, 32'd0);
    end
  end

  task automatic do_reset();
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.flush    = 1'b0;
    bus.iwait    = 1'b0;
    hit_q.delete();
    fill_q.delete();
    repeat (2) @(negedge CLK);
    chk("reset ihit", 32'(bus.ihit), 32'd0);
    chk("reset iREN", 32'(bus.iREN), 32'd0);
    chk("reset iaddr", bus.iaddr, 32'd0);
    chk("reset imemload", bus.imemload, 32'd0);
`ifdef PARAM_ICACHE_PERF_EN
    chk("reset hit_count", hit_count, 32'd0);
    chk("reset miss_count", miss_count, 32'd0);
`endif
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic push_fill(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'(WORDS * 4 - 1);
    for (int i = 0; i < WORDS; i++) fill_q.push_back(base + 32'(4 * i));
  endtask

  // Read one word; called just after a posedge, returns just after a posedge.
  task automatic rd(input logic [31:0] a, input bit miss, input int waits);
    int exp_lat;
    int cyc;
    int waited;
    bit seen;
    if (miss) push_fill(a);
    hit_q.push_back(mem_word(a & ~32'h3));
    exp_lat      = miss ? (WORDS + 2 + waits) : 1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    bus.iwait    = (waits > 0);
    cyc    = 0;
    waited = 0;
    seen   = 1'b0;
    while (!seen && cyc < 50) begin
      @(negedge CLK);
      cyc++;
      if (bus.ihit) begin
        seen = 1'b1;
      end else if (bus.iREN && bus.iwait) begin
        waited++;
        if (waited == waits) begin
          @(posedge CLK);
          #1 bus.iwait = 1'b0;
        end
      end
    end
    chk($sformatf("latency %h", a), cyc, exp_lat);
    @(posedge CLK);
    #1 bus.imemREN = 1'b0;
  endtask

  initial begin
    do_reset();

    rd(32'h0000_0040, 1'b1, 0);
    rd(32'h0000_0044, 1'b0, 0);
    rd(32'h0000_0040, 1'b0, 0);
    rd(32'h0000_0440, 1'b1, 0);
    rd(32'h0000_0444, 1'b0, 0);
    rd(32'h0000_0040, 1'b1, 0);
    rd(32'h0000_0048, 1'b1, 0);
    rd(32'h0000_0040, 1'b0, 0);
    rd(32'hFFFF_FFFC, 1'b1, 0);
    rd(32'hFFFF_FFF8, 1'b0, 0);

    rd(32'h0000_0080, 1'b1, 3);
    rd(32'h0000_0084, 1'b0, 0);

    // Request withdrawn and address moved after the miss is taken; fill must still finish.
    push_fill(32'h0000_0100);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0100;
    @(posedge CLK);
    #1 bus.imemREN = 1'b0;
    bus.imemaddr = 32'h0000_0999;
    repeat (3) @(posedge CLK);
    #1 rd(32'h0000_0104, 1'b0, 0);

    // Flush in IDLE masks a would-be hit and invalidates the line.
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0084;
    bus.flush    = 1'b1;
    @(negedge CLK);
    chk("flush idle ihit", 32'(bus.ihit), 32'd0);
    @(posedge CLK);
    #1 bus.flush = 1'b0;
    bus.imemREN = 1'b0;
    rd(32'h0000_0084, 1'b1, 0);

    // Flush on the last fill beat: abort, line stays invalid.
    do_reset();
    push_fill(32'h0000_0040);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    @(posedge CLK);
    @(posedge CLK);
    #1 bus.flush = 1'b1;
    bus.imemREN = 1'b0;
    @(negedge CLK);
    chk("flush last beat ihit", 32'(bus.ihit), 32'd0);
    @(posedge CLK);
    #1 bus.flush = 1'b0;
    @(negedge CLK);
    chk("flush abort iREN", 32'(bus.iREN), 32'd0);
    @(posedge CLK);
    #1 rd(32'h0000_0040, 1'b1, 0);
`ifdef PARAM_ICACHE_PERF_EN
    chk("perf miss_count", miss_count, 32'd2);
    chk("perf hit_count", hit_count, 32'd1);
`endif

    // Reset in the middle of a fill discards the partial line.
    push_fill(32'h0000_0240);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0240;
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #1 nRST = 1'b0;
    bus.imemREN = 1'b0;
    fill_q.delete();
    @(negedge CLK);
    chk("mid-fill reset iREN", 32'(bus.iREN), 32'd0);
    @(negedge CLK);
    chk("mid-fill reset iREN held", 32'(bus.iREN), 32'd0);
`ifdef PARAM_ICACHE_PERF_EN
    chk("mid-fill reset hit_count", hit_count, 32'd0);
    chk("mid-fill reset miss_count", miss_count, 32'd0);
`endif
    @(posedge CLK);
    #1 nRST = 1'b1;
    rd(32'h0000_0244, 1'b1, 0);
    rd(32'h0000_0040, 1'b1, 0);

    repeat (2) @(negedge CLK);
    chk("hit queue drained", 32'(hit_q.size()), 32'd0);
    chk("fill queue drained", 32'(fill_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
